// File: rtl/twi_pkg.sv
// ---------------------------------------------------------------------------
// twi_pkg
// Shared definitions for the oversampled TWI (I2C) register slave:
//   - twiState_e : protocol state machine encoding
//   - TWI_ACK / TWI_NACK : bus level of the acknowledge bit
//   - TWI_RW_WRITE / TWI_RW_READ : meaning of the R/W bit in the address byte
// ---------------------------------------------------------------------------
package twi_pkg;

   // Protocol states. The ST_ prefix keeps the names clear of the ADDR
   // parameter of the slave.
   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_PTR,
      ST_PTR_ACK,
      ST_WR_DATA,
      ST_WR_ACK,
      ST_RD_DATA,
      ST_RD_ACK
   } twiState_e;

   localparam logic TWI_ACK      = 1'b0;
   localparam logic TWI_NACK     = 1'b1;

   localparam logic TWI_RW_WRITE = 1'b0;
   localparam logic TWI_RW_READ  = 1'b1;

endpackage

// File: rtl/twi_line_filter.sv
// ---------------------------------------------------------------------------
// twi_line_filter
// Two-flop synchroniser followed by a glitch filter for one bus line. The
// filtered output only changes after FILTER_LEN consecutive synchronised
// samples disagree with it, so pulses shorter than that never get through.
// All flops come out of reset at 1, the idle level of an open-drain bus.
//
// Ports:
//   clk    in  system clock
//   resetN in  asynchronous active-low reset
//   in     in  raw pin
//   out    out synchronised, filtered line
// ---------------------------------------------------------------------------
module twi_line_filter
   import twi_pkg::*;
#(
   parameter int FILTER_LEN = 3
) (
   input  logic clk,
   input  logic resetN,
   input  logic in,
   output logic out
);

   localparam int CNT_W = $clog2(FILTER_LEN + 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             out_q;
   logic             out_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // The counter tracks how many samples in a row have disagreed with the
   // current output; any agreeing sample restarts it from zero.
   always_comb begin
      out_d = out_q;
      cnt_d = '0;
      if (sync2_q != out_q) begin
         if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
            out_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Synchroniser and filter state.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         out_q   <= 1'b1;
         cnt_q   <= '0;
      end else begin
         sync1_q <= in;
         sync2_q <= sync1_q;
         out_q   <= out_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out = out_q;

endmodule

// File: rtl/twi_slave_regs.sv
// ---------------------------------------------------------------------------
// twi_slave_regs
// TWI (I2C) slave running entirely on the system clock. It exposes a window
// of NUM_REGS byte registers: a write transaction sets the register pointer
// and then writes bytes with pointer auto-increment; a read transaction
// returns bytes starting at the pointer. Repeated START is supported.
//
// Ports:
//   clk         in  system clock (at least 20x the SCL rate)
//   resetN      in  asynchronous active-low reset
//   scl         in  raw SCL pin
//   sdaIn       in  raw SDA pin
//   sdaOutEn    out 1 = pull SDA low
//   regAddr     out register index for regWrEn
//   regWrData   out write data
//   regWrEn     out one-cycle write strobe
//   regRdAddr   out register index being fetched (the pointer)
//   regRdData   in  combinational read data for regRdAddr
//   regRdStrobe out one-cycle pulse when regRdData is latched for sending
//   busy        out high from a matched address until STOP or NACK exit
// ---------------------------------------------------------------------------
module twi_slave_regs
   import twi_pkg::*;
#(
   parameter logic [6:0] ADDR       = 7'h11,
   parameter int         NUM_REGS   = 16,
   parameter int         FILTER_LEN = 3,
   localparam int        PTR_W      = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             scl,
   input  logic             sdaIn,
   output logic             sdaOutEn,
   output logic [PTR_W-1:0] regAddr,
   output logic [7:0]       regWrData,
   output logic             regWrEn,
   output logic [PTR_W-1:0] regRdAddr,
   input  logic [7:0]       regRdData,
   output logic             regRdStrobe,
   output logic             busy
);

   twiState_e        state_q, state_d;
   logic [3:0]       bitCnt_q, bitCnt_d;
   logic [7:0]       shift_q, shift_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic             rwBit_q, rwBit_d;
   logic             masterAck_q, masterAck_d;

   logic             sdaOutEn_q, sdaOutEn_d;
   logic             regWrEn_q, regWrEn_d;
   logic [PTR_W-1:0] regAddr_q, regAddr_d;
   logic [7:0]       regWrData_q, regWrData_d;
   logic             regRdStrobe_q, regRdStrobe_d;
   logic             busy_q, busy_d;

   logic sclF, sdaF;
   logic sclPrev_q, sdaPrev_q;
   logic sclChg, sdaChg;
   logic sclRise, sclFall, startEv, stopEv;
   logic byteDone, addrMatch, ptrValid;

   twi_line_filter #(.FILTER_LEN(FILTER_LEN)) uSclFilter (
      .clk    (clk),
      .resetN (resetN),
      .in     (scl),
      .out    (sclF)
   );

   twi_line_filter #(.FILTER_LEN(FILTER_LEN)) uSdaFilter (
      .clk    (clk),
      .resetN (resetN),
      .in     (sdaIn),
      .out    (sdaF)
   );

   // START/STOP need SCL high and stable; if both filtered lines move in the
   // same clock the SDA change is treated as ordinary data.
   assign sclChg  = sclF ^ sclPrev_q;
   assign sdaChg  = sdaF ^ sdaPrev_q;
   assign sclRise = sclChg & sclF;
   assign sclFall = sclChg & ~sclF;
   assign startEv = sdaChg & ~sdaF & ~sclChg & sclF;
   assign stopEv  = sdaChg & sdaF & ~sclChg & sclF;

   assign byteDone  = (bitCnt_q == 4'd8);
   assign addrMatch = (shift_q[7:1] == ADDR);
   assign ptrValid  = ({24'd0, shift_q} < NUM_REGS);

   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(NUM_REGS - 1)) begin
         return '0;
      end
      return p + PTR_W'(1);
   endfunction

   // State register.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and datapath logic. Bits are shifted in on SCL rising edges;
   // every byte/ack decision is taken on the SCL falling edge that follows.
   // The write pointer advances the clock after the write strobe.
   always_comb begin
      state_d     = state_q;
      bitCnt_d    = bitCnt_q;
      shift_d     = shift_q;
      ptr_d       = ptr_q;
      rwBit_d     = rwBit_q;
      masterAck_d = masterAck_q;
      if (regWrEn_q) begin
         ptr_d = nextPtr(ptr_q);
      end
      if (stopEv) begin
         state_d = ST_IDLE;
      end else if (startEv) begin
         state_d  = ST_ADDR;
         bitCnt_d = 4'd0;
      end else begin
         case (state_q)
            ST_ADDR, ST_PTR, ST_WR_DATA: begin
               if (sclRise && !byteDone) begin
                  shift_d  = {shift_q[6:0], sdaF};
                  bitCnt_d = bitCnt_q + 4'd1;
               end else if (sclFall && byteDone) begin
                  bitCnt_d = 4'd0;
                  if (state_q == ST_ADDR) begin
                     if (addrMatch) begin
                        state_d = ST_ADDR_ACK;
                        rwBit_d = shift_q[0];
                     end else begin
                        state_d = ST_IDLE;
                     end
                  end else if (state_q == ST_PTR) begin
                     if (ptrValid) begin
                        ptr_d   = shift_q[PTR_W-1:0];
                        state_d = ST_PTR_ACK;
                     end else begin
                        state_d = ST_IDLE;
                     end
                  end else begin
                     state_d = ST_WR_ACK;
                  end
               end
            end
            ST_ADDR_ACK: begin
               if (sclFall) begin
                  bitCnt_d = 4'd0;
                  if (rwBit_q == TWI_RW_READ) begin
                     shift_d = regRdData;
                     state_d = ST_RD_DATA;
                  end else begin
                     state_d = ST_PTR;
                  end
               end
            end
            ST_PTR_ACK, ST_WR_ACK: begin
               if (sclFall) begin
                  bitCnt_d = 4'd0;
                  state_d  = ST_WR_DATA;
               end
            end
            ST_RD_DATA: begin
               if (sclRise && !byteDone) begin
                  bitCnt_d = bitCnt_q + 4'd1;
               end else if (sclFall) begin
                  if (byteDone) begin
                     state_d = ST_RD_ACK;
                  end else begin
                     shift_d = {shift_q[6:0], 1'b1};
                  end
               end
            end
            ST_RD_ACK: begin
               // Advancing the pointer at the ack sample gives regRdData
               // time to settle before the load on the following fall.
               if (sclRise) begin
                  masterAck_d = sdaF;
                  if (sdaF == TWI_ACK) begin
                     ptr_d = nextPtr(ptr_q);
                  end
               end else if (sclFall) begin
                  if (masterAck_q == TWI_ACK) begin
                     shift_d  = regRdData;
                     bitCnt_d = 4'd0;
                     state_d  = ST_RD_DATA;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Output logic. SDA drive only changes on SCL falling edges (or STOP),
   // so the slave never moves SDA while SCL is high.
   always_comb begin
      sdaOutEn_d    = sdaOutEn_q;
      regWrEn_d     = 1'b0;
      regRdStrobe_d = 1'b0;
      regAddr_d     = regAddr_q;
      regWrData_d   = regWrData_q;
      busy_d        = busy_q;
      if (stopEv) begin
         sdaOutEn_d = 1'b0;
         busy_d     = 1'b0;
      end else if (!startEv) begin
         case (state_q)
            ST_ADDR: begin
               if (sclFall) begin
                  if (!byteDone) begin
                     sdaOutEn_d = 1'b0;
                  end else if (addrMatch) begin
                     sdaOutEn_d = 1'b1;
                     busy_d     = 1'b1;
                  end else begin
                     busy_d = 1'b0;
                  end
               end
            end
            ST_PTR: begin
               if (sclFall && byteDone) begin
                  if (ptrValid) begin
                     sdaOutEn_d = 1'b1;
                  end else begin
                     busy_d = 1'b0;
                  end
               end
            end
            ST_WR_DATA: begin
               if (sclFall && byteDone) begin
                  sdaOutEn_d  = 1'b1;
                  regWrEn_d   = 1'b1;
                  regAddr_d   = ptr_q;
                  regWrData_d = shift_q;
               end
            end
            ST_ADDR_ACK: begin
               if (sclFall) begin
                  if (rwBit_q == TWI_RW_READ) begin
                     sdaOutEn_d    = ~regRdData[7];
                     regRdStrobe_d = 1'b1;
                  end else begin
                     sdaOutEn_d = 1'b0;
                  end
               end
            end
            ST_PTR_ACK, ST_WR_ACK: begin
               if (sclFall) begin
                  sdaOutEn_d = 1'b0;
               end
            end
            ST_RD_DATA: begin
               if (sclFall) begin
                  sdaOutEn_d = byteDone ? 1'b0 : ~shift_q[6];
               end
            end
            ST_RD_ACK: begin
               if (sclFall) begin
                  if (masterAck_q == TWI_ACK) begin
                     sdaOutEn_d    = ~regRdData[7];
                     regRdStrobe_d = 1'b1;
                  end else begin
                     sdaOutEn_d = 1'b0;
                     busy_d     = 1'b0;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         sclPrev_q     <= 1'b1;
         sdaPrev_q     <= 1'b1;
         bitCnt_q      <= 4'd0;
         shift_q       <= 8'd0;
         ptr_q         <= '0;
         rwBit_q       <= 1'b0;
         masterAck_q   <= 1'b1;
         sdaOutEn_q    <= 1'b0;
         regWrEn_q     <= 1'b0;
         regAddr_q     <= '0;
         regWrData_q   <= 8'd0;
         regRdStrobe_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         sclPrev_q     <= sclF;
         sdaPrev_q     <= sdaF;
         bitCnt_q      <= bitCnt_d;
         shift_q       <= shift_d;
         ptr_q         <= ptr_d;
         rwBit_q       <= rwBit_d;
         masterAck_q   <= masterAck_d;
         sdaOutEn_q    <= sdaOutEn_d;
         regWrEn_q     <= regWrEn_d;
         regAddr_q     <= regAddr_d;
         regWrData_q   <= regWrData_d;
         regRdStrobe_q <= regRdStrobe_d;
         busy_q        <= busy_d;
      end
   end

   assign sdaOutEn    = sdaOutEn_q;
   assign regWrEn     = regWrEn_q;
   assign regAddr     = regAddr_q;
   assign regWrData   = regWrData_q;
   assign regRdStrobe = regRdStrobe_q;
   assign busy        = busy_q;
   assign regRdAddr   = ptr_q;

endmodule

// File: tb/tb_twi_slave_regs.sv
// ---------------------------------------------------------------------------
// tb_twi_slave_regs
// Bench for twi_slave_regs with default parameters (ADDR 0x11, 16 registers,
// FILTER_LEN 3). A bit-banged master drives SCL/SDA with 10 clk quarter
// periods; the bench holds a 16-byte register file answering regRdData.
// ---------------------------------------------------------------------------
module tb_twi_slave_regs;

   localparam int Q = 10;

   logic       clk = 1'b0;
   logic       resetN = 1'b0;
   logic       scl = 1'b1;
   logic       sdaM = 1'b1;
   logic       sdaIn;
   logic       sdaOutEn;
   logic [3:0] regAddr;
   logic [7:0] regWrData;
   logic       regWrEn;
   logic [3:0] regRdAddr;
   logic [7:0] regRdData;
   logic       regRdStrobe;
   logic       busy;

   logic [7:0]  regs [16];
   logic        preloadDone = 1'b0;
   logic [11:0] wrLog [$];
   int          strobeCnt = 0;
   int          drvCnt = 0;
   int          checks = 0;
   int          errors = 0;

   twi_slave_regs dut (
      .clk         (clk),
      .resetN      (resetN),
      .scl         (scl),
      .sdaIn       (sdaIn),
      .sdaOutEn    (sdaOutEn),
      .regAddr     (regAddr),
      .regWrData   (regWrData),
      .regWrEn     (regWrEn),
      .regRdAddr   (regRdAddr),
      .regRdData   (regRdData),
      .regRdStrobe (regRdStrobe),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Open-drain bus: either side can pull SDA low.
   assign sdaIn     = sdaM & ~sdaOutEn;
   assign regRdData = regs[regRdAddr];

   // Register file, write log and strobe/drive counters, sampled on the
   // falling clock edge away from the DUT's active edge.
   always @(negedge clk) begin
      if (!preloadDone) begin
         for (int i = 0; i < 16; i++) begin
            regs[i] = 8'h80 + 8'(i);
         end
         preloadDone = 1'b1;
      end
      if (regWrEn) begin
         wrLog.push_back({regAddr, regWrData});
         regs[regAddr] = regWrData;
      end
      if (regRdStrobe) strobeCnt++;
      if (sdaOutEn) drvCnt++;
   end

   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   function automatic logic [11:0] logEntry(input int idx);
      if (idx < wrLog.size()) return wrLog[idx];
      return 12'hxxx;
   endfunction

   task automatic waitClk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Works both from an idle bus and as a repeated START with SCL low.
   task automatic startCond();
      sdaM = 1'b1; waitClk(Q);
      scl  = 1'b1; waitClk(Q);
      sdaM = 1'b0; waitClk(Q);
      scl  = 1'b0; waitClk(Q);
   endtask

   task automatic stopCond();
      sdaM = 1'b0; waitClk(Q);
      scl  = 1'b1; waitClk(Q);
      sdaM = 1'b1; waitClk(Q);
   endtask

   // Optional one-clock glitch to the opposite level while SCL is high.
   task automatic writeBit(input logic b, input logic glitch);
      sdaM = b; waitClk(Q);
      scl  = 1'b1; waitClk(Q);
      if (glitch) begin
         sdaM = ~b; waitClk(1);
         sdaM = b;  waitClk(Q - 1);
      end else begin
         waitClk(Q);
      end
      scl = 1'b0; waitClk(Q);
   endtask

   task automatic readBit(output logic b);
      sdaM = 1'b1; waitClk(Q);
      scl  = 1'b1; waitClk(Q);
      b = sdaIn;   waitClk(Q);
      scl  = 1'b0; waitClk(Q);
   endtask

   task automatic sendByte(input logic [7:0] v, input logic [7:0] glitchMask,
                           output logic ack);
      for (int i = 7; i >= 0; i--) writeBit(v[i], glitchMask[i]);
      readBit(ack);
   endtask

   task automatic recvByte(input logic mAck, output logic [7:0] v);
      for (int i = 7; i >= 0; i--) readBit(v[i]);
      writeBit(mAck, 1'b0);
   endtask

   typedef struct {
      string      name;
      logic [7:0] addrByte;
      logic [7:0] ptrByte;
      int         nData;
      logic [7:0] d0;
      logic [7:0] d1;
      logic       expAddrAck;
      logic       expPtrAck;
      int         expWr;
      logic [3:0] wa0;
      logic [3:0] wa1;
      logic [3:0] expPtr;
   } wrVec_t;

   wrVec_t vecs [6];

   task automatic applyStimulus(input wrVec_t v);
      logic ack;
      int   wrStart;
      int   drvStart;
      wrStart  = wrLog.size();
      drvStart = drvCnt;
      startCond();
      sendByte(v.addrByte, 8'h00, ack);
      checkOutput({v.name, ".addrAck"}, 32'(ack), 32'(v.expAddrAck));
      if (v.expAddrAck == 1'b0) begin
         checkOutput({v.name, ".busy"}, 32'(busy), 32'd1);
         sendByte(v.ptrByte, 8'h00, ack);
         checkOutput({v.name, ".ptrAck"}, 32'(ack), 32'(v.expPtrAck));
         if (v.expPtrAck == 1'b0) begin
            if (v.nData > 0) begin
               sendByte(v.d0, 8'h00, ack);
               checkOutput({v.name, ".d0Ack"}, 32'(ack), 32'd0);
            end
            if (v.nData > 1) begin
               sendByte(v.d1, 8'h00, ack);
               checkOutput({v.name, ".d1Ack"}, 32'(ack), 32'd0);
            end
         end
      end
      stopCond();
      waitClk(Q);
      checkOutput({v.name, ".wrCount"}, 32'(wrLog.size() - wrStart), 32'(v.expWr));
      if (v.expWr > 0)
         checkOutput({v.name, ".wr0"}, 32'(logEntry(wrStart)), 32'({v.wa0, v.d0}));
      if (v.expWr > 1)
         checkOutput({v.name, ".wr1"}, 32'(logEntry(wrStart + 1)), 32'({v.wa1, v.d1}));
      checkOutput({v.name, ".ptr"}, 32'(regRdAddr), 32'(v.expPtr));
      checkOutput({v.name, ".busyAfter"}, 32'(busy), 32'd0);
      if (v.expAddrAck == 1'b1)
         checkOutput({v.name, ".noDrive"}, 32'(drvCnt - drvStart), 32'd0);
   endtask

   initial begin
      logic       ack;
      logic [7:0] data;
      int         strobeStart;
      int         wrStart;

      vecs[0] = '{"wrBasic",  8'h22, 8'h03, 2, 8'hA5, 8'h5A, 1'b0, 1'b0, 2, 4'd3,  4'd4, 4'd5};
      vecs[1] = '{"wrongAdr", 8'h12, 8'h00, 0, 8'h00, 8'h00, 1'b1, 1'b1, 0, 4'd0,  4'd0, 4'd5};
      vecs[2] = '{"ptrWrap",  8'h22, 8'h0F, 2, 8'h11, 8'h22, 1'b0, 1'b0, 2, 4'd15, 4'd0, 4'd1};
      vecs[3] = '{"ptrOob",   8'h22, 8'h10, 0, 8'h00, 8'h00, 1'b0, 1'b1, 0, 4'd0,  4'd0, 4'd1};
      vecs[4] = '{"rdSetup",  8'h22, 8'h05, 2, 8'h3C, 8'hC3, 1'b0, 1'b0, 2, 4'd5,  4'd6, 4'd7};
      vecs[5] = '{"setPtr5",  8'h22, 8'h05, 0, 8'h00, 8'h00, 1'b0, 1'b0, 0, 4'd0,  4'd0, 4'd5};

      // Reset state
      waitClk(3);
      checkOutput("rst.sdaOutEn",    32'(sdaOutEn),    32'd0);
      checkOutput("rst.regWrEn",     32'(regWrEn),     32'd0);
      checkOutput("rst.regRdStrobe", 32'(regRdStrobe), 32'd0);
      checkOutput("rst.busy",        32'(busy),        32'd0);
      checkOutput("rst.regAddr",     32'(regAddr),     32'd0);
      checkOutput("rst.regWrData",   32'(regWrData),   32'd0);
      checkOutput("rst.regRdAddr",   32'(regRdAddr),   32'd0);
      resetN = 1'b1;
      waitClk(10);

      for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

      // Read two bytes from pointer 5: ACK the first, NACK the second.
      strobeStart = strobeCnt;
      startCond();
      sendByte(8'h23, 8'h00, ack);
      checkOutput("rd.addrAck", 32'(ack), 32'd0);
      recvByte(1'b0, data);
      checkOutput("rd.byte0", 32'(data), 32'h3C);
      recvByte(1'b1, data);
      checkOutput("rd.byte1", 32'(data), 32'hC3);
      stopCond();
      waitClk(Q);
      checkOutput("rd.strobes", 32'(strobeCnt - strobeStart), 32'd2);
      checkOutput("rd.ptr",     32'(regRdAddr), 32'd6);
      checkOutput("rd.busy",    32'(busy), 32'd0);

      // Set pointer 2, repeated START, read back the untouched regs[2].
      startCond();
      sendByte(8'h22, 8'h00, ack);
      checkOutput("rs.addrAck", 32'(ack), 32'd0);
      sendByte(8'h02, 8'h00, ack);
      checkOutput("rs.ptrAck", 32'(ack), 32'd0);
      startCond();
      sendByte(8'h23, 8'h00, ack);
      checkOutput("rs.addrAckR", 32'(ack), 32'd0);
      recvByte(1'b1, data);
      checkOutput("rs.byte", 32'(data), 32'h82);
      stopCond();
      waitClk(Q);
      checkOutput("rs.ptr", 32'(regRdAddr), 32'd2);

      // One-clock SDA glitches while SCL is high on every data bit.
      wrStart = wrLog.size();
      startCond();
      sendByte(8'h22, 8'h00, ack);
      sendByte(8'h07, 8'h00, ack);
      checkOutput("gl.ptrAck", 32'(ack), 32'd0);
      sendByte(8'h99, 8'hFF, ack);
      checkOutput("gl.dataAck", 32'(ack), 32'd0);
      stopCond();
      waitClk(Q);
      checkOutput("gl.wrCount", 32'(wrLog.size() - wrStart), 32'd1);
      checkOutput("gl.wr0", 32'(logEntry(wrStart)), 32'h799);
      checkOutput("gl.ptr", 32'(regRdAddr), 32'd8);

      // Reset while the slave drives bit 7 (0) of regs[4] = 0x5A.
      startCond();
      sendByte(8'h22, 8'h00, ack);
      sendByte(8'h04, 8'h00, ack);
      stopCond();
      startCond();
      sendByte(8'h23, 8'h00, ack);
      checkOutput("mr.addrAck", 32'(ack), 32'd0);
      checkOutput("mr.driveLow", 32'(sdaOutEn), 32'd1);
      #2 resetN = 1'b0;
      #1;
      checkOutput("mr.sdaOutEn", 32'(sdaOutEn), 32'd0);
      checkOutput("mr.busy", 32'(busy), 32'd0);
      checkOutput("mr.ptr", 32'(regRdAddr), 32'd0);
      scl  = 1'b1;
      sdaM = 1'b1;
      waitClk(10);
      resetN = 1'b1;
      waitClk(10);
      startCond();
      sendByte(8'h23, 8'h00, ack);
      checkOutput("mr.addrAck2", 32'(ack), 32'd0);
      recvByte(1'b1, data);
      checkOutput("mr.byte", 32'(data), 32'h22);
      stopCond();
      waitClk(Q);
      checkOutput("mr.ptrAfter", 32'(regRdAddr), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
